pcie_egress: RTL

- Transmit-side TLP builder for the PCIe bridge. Takes one command at a time and drives the outgoing 32-bit AXI stream toward the PCIe core.
- Two command types:
  - Memory Write: header, then payload pulled from the local buffer.
  - Memory Read request: header only.
- Pairs with the ingress parser. Ingress consumes host writes and completions; this block issues device-initiated writes and read requests, for example to the status, write and read buffer addresses programmed through ingress.

---
 rtl/pcie_egress.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/pcie_egress.sv
// Transmit-side TLP builder: emits Memory Write / Memory Read request TLPs on a 32-bit AXI stream.
// Write payload is pulled from a local buffer through a 2-entry prefetch queue.
module pcie_egress #(
    parameter logic [2:0] TRAFFIC_CLASS = 3'b000,
    parameter logic [1:0] ATTR          = 2'b00,
    parameter bit         ADDR64_ENABLE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_requester_id,
    input  logic        i_cmd_wr_stb,
    input  logic        i_cmd_rd_stb,
    input  logic [63:0] i_cmd_addr,
    input  logic [9:0]  i_cmd_dword_count,
    input  logic [7:0]  i_cmd_tag,
    input  logic [31:0] i_cmd_buf_offset,
    output logic        o_busy,
    output logic        o_done_stb,
    output logic        o_cmd_err_stb,
    output logic        o_buf_re,
    output logic [31:0] o_buf_addr,
    input  logic [31:0] i_buf_data,
    output logic        o_axi_egress_valid,
    input  logic        i_axi_egress_ready,
    output logic [31:0] o_axi_egress_data,
    output logic [3:0]  o_axi_egress_keep,
    output logic        o_axi_egress_last,
    output logic [3:0]  o_state,
    output logic [7:0]  o_egress_count
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        HDR0 = 4'd1,
        HDR1 = 4'd2,
        HDR2 = 4'd3,
        HDR3 = 4'd4,
        DATA = 4'd5,
        DONE = 4'd6
    } state_e;

    state_e      state_q, state_d;
    logic        is_wr_q;
    logic        hdr4_q;
    logic [63:0] addr_q;
    logic [9:0]  count_q;
    logic [7:0]  tag_q;
    logic [31:0] buf_addr_q;
    logic [10:0] words_req_q;
    logic [10:0] words_sent_q;
    logic        rd_pending_q;
    logic [1:0]  fill_q;
    logic [31:0] fifo0_q, fifo1_q;
    logic [7:0]  egress_count_q;
    logic        err_q;

    logic [10:0] total_words;
    logic        accept_wr, accept_rd, accept, err_d;
    logic        in_hdr, fire, pop, buf_re;
    logic [1:0]  fill_next;
    logic        beat_valid, beat_last;
    logic [31:0] beat_data;
    logic [31:0] dw0, dw1, addr_lo;
    logic        addr_lsb_unused;

    // Byte-offset bits of the address never reach the header.
    assign addr_lsb_unused = ^i_cmd_addr[1:0];

    assign total_words = (count_q == 10'd0) ? 11'd1024 : {1'b0, count_q};
    assign accept_wr   = (state_q == IDLE) && i_cmd_wr_stb;
    assign accept_rd   = (state_q == IDLE) && !i_cmd_wr_stb && i_cmd_rd_stb;
    assign accept      = accept_wr || accept_rd;
    assign err_d       = ((state_q != IDLE) && (i_cmd_wr_stb || i_cmd_rd_stb))
                      || ((state_q == IDLE) && i_cmd_wr_stb && i_cmd_rd_stb);
    assign in_hdr      = state_q inside {HDR0, HDR1, HDR2, HDR3};

    assign dw0     = {1'b0, is_wr_q, hdr4_q, 5'b00000, 1'b0, TRAFFIC_CLASS,
                      6'b000000, ATTR, 2'b00, count_q};
    assign dw1     = {i_requester_id, tag_q, (count_q == 10'd1) ? 4'h0 : 4'hF, 4'hF};
    assign addr_lo = {addr_q[31:2], 2'b00};

    assign fire = beat_valid && i_axi_egress_ready;
    assign pop  = (state_q == DATA) && fire;

    // A read issued now lands next cycle, so it may only go out if the queue
    // will still have a free slot after this cycle's push and pop.
    assign fill_next = fill_q + {1'b0, rd_pending_q} - {1'b0, pop};
    assign buf_re    = is_wr_q && (in_hdr || (state_q == DATA))
                    && (words_req_q < total_words) && (fill_next < 2'd2);

    always_comb begin
        state_d    = state_q;
        beat_valid = 1'b0;
        beat_data  = 32'd0;
        beat_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = HDR0;
            end
            HDR0: begin
                beat_valid = 1'b1;
                beat_data  = dw0;
                if (i_axi_egress_ready) state_d = HDR1;
            end
            HDR1: begin
                beat_valid = 1'b1;
                beat_data  = dw1;
                if (i_axi_egress_ready) state_d = HDR2;
            end
            HDR2: begin
                beat_valid = 1'b1;
                beat_data  = hdr4_q ? addr_q[63:32] : addr_lo;
                beat_last  = !hdr4_q && !is_wr_q;
                if (i_axi_egress_ready) state_d = hdr4_q ? HDR3 : (is_wr_q ? DATA : DONE);
            end
            HDR3: begin
                beat_valid = 1'b1;
                beat_data  = addr_lo;
                beat_last  = !is_wr_q;
                if (i_axi_egress_ready) state_d = is_wr_q ? DATA : DONE;
            end
            DATA: begin
                beat_valid = (fill_q != 2'd0);
                beat_data  = beat_valid ? fifo0_q : 32'd0;
                beat_last  = beat_valid && (words_sent_q == total_words - 11'd1);
                if (beat_valid && beat_last && i_axi_egress_ready) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            is_wr_q        <= 1'b0;
            hdr4_q         <= 1'b0;
            addr_q         <= 64'd0;
            count_q        <= 10'd0;
            tag_q          <= 8'd0;
            buf_addr_q     <= 32'd0;
            words_req_q    <= 11'd0;
            words_sent_q   <= 11'd0;
            rd_pending_q   <= 1'b0;
            fill_q         <= 2'd0;
            egress_count_q <= 8'd0;
            err_q          <= 1'b0;
        end else begin
            state_q      <= state_d;
            err_q        <= err_d;
            rd_pending_q <= buf_re;
            fill_q       <= fill_next;
            if (accept) begin
                is_wr_q      <= accept_wr;
                hdr4_q       <= ADDR64_ENABLE && (i_cmd_addr[63:32] != 32'd0);
                addr_q       <= i_cmd_addr;
                count_q      <= i_cmd_dword_count;
                tag_q        <= i_cmd_tag;
                buf_addr_q   <= i_cmd_buf_offset;
                words_req_q  <= 11'd0;
                words_sent_q <= 11'd0;
            end else begin
                if (buf_re) begin
                    buf_addr_q  <= buf_addr_q + 32'd1;
                    words_req_q <= words_req_q + 11'd1;
                end
                if (pop) words_sent_q <= words_sent_q + 11'd1;
            end
            if (state_q == DONE) egress_count_q <= egress_count_q + 8'd1;
        end
    end

    // NOTE: payload storage has no reset; fill_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (pop) begin
            fifo0_q <= (rd_pending_q && (fill_q == 2'd1)) ? i_buf_data : fifo1_q;
            if (rd_pending_q) fifo1_q <= i_buf_data;
        end else if (rd_pending_q) begin
            if (fill_q == 2'd0) fifo0_q <= i_buf_data;
            else                fifo1_q <= i_buf_data;
        end
    end

    assign o_busy             = (state_q != IDLE) && (state_q != DONE);
    assign o_done_stb         = (state_q == DONE);
    assign o_cmd_err_stb      = err_q;
    assign o_buf_re           = buf_re;
    assign o_buf_addr         = buf_addr_q;
    assign o_axi_egress_valid = beat_valid;
    assign o_axi_egress_data  = beat_data;
    assign o_axi_egress_keep  = {4{beat_valid}};
    assign o_axi_egress_last  = beat_last;
    assign o_state            = state_q;
    assign o_egress_count     = egress_count_q;

endmodule
